// File: rtl/size_exploration_sequencer.sv
// Run controller for an arithmetic unit under exploration: serially loads two
// operands, pulses one execute cycle, waits the unit latency and captures the result.
module size_exploration_sequencer #(
    parameter int WIDTH        = 6,
    parameter int LATENCY      = 0,
    parameter int RESULT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    accumulate_i,
    input  logic                    ser_a_i,
    input  logic                    ser_b_i,
    output logic [WIDTH-1:0]        op_a_o,
    output logic [WIDTH-1:0]        op_b_o,
    output logic                    dut_clr_o,
    output logic                    dut_en_o,
    input  logic [RESULT_WIDTH-1:0] result_i,
    input  logic [1:0]              byte_sel_i,
    output logic [7:0]              byte_out_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_CAPT,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_BIT  = 4'(WIDTH - 1);
    localparam logic [3:0] WAIT_INIT = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_e                  state_q;
    logic [3:0]              bit_cnt_q;
    logic [3:0]              wait_cnt_q;
    logic [RESULT_WIDTH-1:0] capt_q;
    logic [31:0]             capt_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_a_o     <= '0;
            op_b_o     <= '0;
            capt_q     <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            dut_clr_o  <= 1'b0;
            dut_en_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            dut_clr_o <= 1'b0;
            dut_en_o  <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q   <= S_LOAD;
                        dut_clr_o <= ~accumulate_i;
                        bit_cnt_q <= '0;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    op_a_o    <= {op_a_o[WIDTH-2:0], ser_a_i};
                    op_b_o    <= {op_b_o[WIDTH-2:0], ser_b_i};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_q  <= S_EXEC;
                        dut_en_o <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // A zero-latency unit has its result ready right after EXEC.
                    if (LATENCY > 0) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= WAIT_INIT;
                    end else begin
                        state_q <= S_CAPT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= S_CAPT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                S_CAPT: begin
                    capt_q  <= result_i;
                    state_q <= S_DONE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Zero-extend so byte lanes above RESULT_WIDTH read back as 0.
    assign capt_ext = 32'(capt_q);

    always_comb begin
        byte_out_o = 8'd0;
        case (byte_sel_i)
            2'd0:    byte_out_o = capt_ext[7:0];
            2'd1:    byte_out_o = capt_ext[15:8];
            2'd2:    byte_out_o = capt_ext[23:16];
            default: byte_out_o = capt_ext[31:24];
        endcase
    end

endmodule

// File: tb/tb_size_exploration_sequencer.sv
// Bench for size_exploration_sequencer: three configurations driven against a
// small unit model, results checked against an arithmetic reference per run.
module tb_size_exploration_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0]       start_s, acc_s, sa, sb;
    logic [2:0][1:0]  bsel;
    logic [2:0][1:0]  mode;
    logic [2:0][15:0] opa, opb;
    logic [2:0]       clr, en, busy, done;
    logic [2:0][7:0]  bout;
    logic [2:0][31:0] res;

    logic [5:0] opa0, opb0, opa2, opb2;
    logic [1:0] opa1, opb1;
    assign opa[0] = 16'(opa0);
    assign opb[0] = 16'(opb0);
    assign opa[1] = 16'(opa1);
    assign opb[1] = 16'(opb1);
    assign opa[2] = 16'(opa2);
    assign opb[2] = 16'(opb2);

    size_exploration_sequencer #(.WIDTH(6), .LATENCY(0), .RESULT_WIDTH(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .accumulate_i(acc_s[0]),
        .ser_a_i(sa[0]), .ser_b_i(sb[0]), .op_a_o(opa0), .op_b_o(opb0),
        .dut_clr_o(clr[0]), .dut_en_o(en[0]), .result_i(res[0]),
        .byte_sel_i(bsel[0]), .byte_out_o(bout[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    size_exploration_sequencer #(.WIDTH(2), .LATENCY(15), .RESULT_WIDTH(12)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .accumulate_i(acc_s[1]),
        .ser_a_i(sa[1]), .ser_b_i(sb[1]), .op_a_o(opa1), .op_b_o(opb1),
        .dut_clr_o(clr[1]), .dut_en_o(en[1]), .result_i(res[1][11:0]),
        .byte_sel_i(bsel[1]), .byte_out_o(bout[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    size_exploration_sequencer #(.WIDTH(6), .LATENCY(1), .RESULT_WIDTH(16)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[2]), .accumulate_i(acc_s[2]),
        .ser_a_i(sa[2]), .ser_b_i(sb[2]), .op_a_o(opa2), .op_b_o(opb2),
        .dut_clr_o(clr[2]), .dut_en_o(en[2]), .result_i(res[2][15:0]),
        .byte_sel_i(bsel[2]), .byte_out_o(bout[2]), .busy_o(busy[2]), .done_o(done[2])
    );

    // Unit under exploration: mode 0 adder, 1 multiplier, 2 multiply-accumulate.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (clr[k]) begin
                    res[k] <= 32'd0;
                end else if (en[k]) begin
                    case (mode[k])
                        2'd0:    res[k] <= 32'(opa[k]) + 32'(opb[k]);
                        2'd1:    res[k] <= 32'(opa[k]) * 32'(opb[k]);
                        default: res[k] <= res[k] + 32'(opa[k]) * 32'(opb[k]);
                    endcase
                end
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [2:0][31:0] model_acc;
    logic [2:0][31:0] prev_cap;

    function automatic int wd(input int k);
        return (k == 1) ? 2 : 6;
    endfunction

    function automatic int lt(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 15 : 1);
    endfunction

    function automatic logic [31:0] rmask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : ((k == 1) ? 32'h0000_0FFF : 32'h0000_FFFF);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run on instance k; entered and left on a falling edge with the
    // instance in IDLE or DONE, so consecutive calls give back-to-back runs.
    task automatic run(input int k, input logic acc_in, input logic [15:0] a,
                       input logic [15:0] b, input bit junk);
        int w, lim, done_at, en_cnt, en_at, clr_cnt;
        logic [63:0] val;
        logic [31:0] cap;
        w   = wd(k);
        lim = w + lt(k) + 3;
        case (mode[k])
            2'd0:    val = 64'(a) + 64'(b);
            2'd1:    val = 64'(a) * 64'(b);
            default: val = 64'(acc_in ? model_acc[k] : 32'd0) + 64'(a) * 64'(b);
        endcase
        model_acc[k] = val[31:0];
        cap = val[31:0] & rmask(k);
        start_s[k] = 1'b1;
        acc_s[k]   = acc_in;
        done_at = 0; en_cnt = 0; en_at = 0; clr_cnt = 0;
        for (int c = 1; c <= lim + 4 && done_at == 0; c++) begin
            @(negedge clk);
            if (en[k]) begin
                en_cnt++;
                en_at = c;
            end
            if (clr[k]) clr_cnt++;
            if (c == 1) begin
                chk("clr_first", 64'(clr[k]), 64'(!acc_in));
                chk("busy_load", 64'(busy[k]), 64'd1);
            end
            if (c == 2) begin
                bsel[k] = 2'd0;
                #1 chk("prev_hold", 64'(bout[k]), 64'(prev_cap[k][7:0]));
            end
            if (c == lim - 1) chk("busy_capt", 64'(busy[k]), 64'd1);
            if (done[k]) done_at = c;
            start_s[k] = (done[k] || !junk) ? 1'b0 : 1'(($urandom % 4) == 0);
            acc_s[k]   = 1'($urandom);
            if (c <= w) begin
                sa[k] = a[w-c];
                sb[k] = b[w-c];
            end else begin
                sa[k] = 1'($urandom);
                sb[k] = 1'($urandom);
            end
        end
        chk("done_time", 64'(done_at), 64'(lim));
        chk("en_count", 64'(en_cnt), 64'd1);
        chk("en_cycle", 64'(en_at), 64'(w + 1));
        chk("clr_count", 64'(clr_cnt), 64'(!acc_in));
        chk("op_a", 64'(opa[k]), 64'(a));
        chk("op_b", 64'(opb[k]), 64'(b));
        chk("busy_done", 64'(busy[k]), 64'd0);
        for (int s = 0; s < 4; s++) begin
            bsel[k] = 2'(s);
            #1 chk("byte_out", 64'(bout[k]), 64'((cap >> (8 * s)) & 32'hFF));
        end
        prev_cap[k] = cap;
        $display("run inst=%0d mode=%0d acc=%0d a=%0d b=%0d result=0x%0h done_at=%0d",
                 k, mode[k], acc_in, a, b, cap, done_at);
    endtask

    initial begin
        int k;
        logic [15:0] a, b, wm;
        rst_n = 1'b0;
        start_s = '0; acc_s = '0; sa = '0; sb = '0; bsel = '0; mode = '0;
        model_acc = '0; prev_cap = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_done", 64'(done[i]), 64'd0);
            chk("rst_en", 64'(en[i] | clr[i]), 64'd0);
            chk("rst_op_a", 64'(opa[i]), 64'd0);
            chk("rst_byte", 64'(bout[i]), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        mode[0] = 2'd0; run(0, 1'b0, 16'd45, 16'd3, 1'b0);
        mode[0] = 2'd1; run(0, 1'b0, 16'd63, 16'd63, 1'b1);
        mode[2] = 2'd2; run(2, 1'b0, 16'd2, 16'd3, 1'b1);
        run(2, 1'b1, 16'd4, 16'd5, 1'b1);
        mode[1] = 2'd2; run(1, 1'b0, 16'd2, 16'd3, 1'b1);
        run(1, 1'b1, 16'd3, 16'd3, 1'b1);

        for (int r = 0; r < 24; r++) begin
            k  = int'($urandom % 3);
            wm = 16'((32'd1 << wd(k)) - 1);
            a  = 16'($urandom) & wm;
            b  = 16'($urandom) & wm;
            mode[k] = 2'($urandom % 3);
            run(k, 1'($urandom), a, b, 1'b1);
            repeat ($urandom % 3) @(negedge clk);
        end

        // Asynchronous reset in the middle of LOAD.
        start_s[0] = 1'b1; acc_s[0] = 1'b0; sa[0] = 1'b1; sb[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        bsel[0] = 2'd0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_done", 64'(done[0]), 64'd0);
        chk("midrst_op_a", 64'(opa[0]), 64'd0);
        chk("midrst_byte", 64'(bout[0]), 64'd0);
        model_acc = '0; prev_cap = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy[0]), 64'd0);
        chk("idle_done", 64'(done[0]), 64'd0);
        mode[0] = 2'd1;
        run(0, 1'b1, 16'd7, 16'd9, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
